// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: attract/serve/rally/point/game-over flow, scores, ball direction, serve timing.
// Optional hit-count ball speedup is enabled by defining PONG_HIT_SPEEDUP_EN.
module pong_game_ctrl #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 11
) (
  input  logic       clk7_159,
  input  logic       _reset,
  input  logic       _vsync,
  input  logic       _hit1,
  input  logic       _hit2,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       coin_start,
  output logic       attract,
  output logic       serve,
  output logic       ball_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] speed,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic       vsync_q, hit1_q, hit2_q, coin_q;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic       dir_q, dir_d;
  logic       serve_q, serve_d;
  logic       attract_q, attract_d;
  logic       game_over_q, game_over_d;
  logic [1:0] speed_q, speed_d;
  logic       p2_pt_q, p2_pt_d;   // scorer of the pending point: 1 = player 2
`ifdef PONG_HIT_SPEEDUP_EN
  logic [2:0] hits_q, hits_d;
`endif

  logic       frame_tick, hit1_ev, hit2_ev, start_ev;
  logic [3:0] score1_inc, score2_inc;
  logic       win_pt;

  assign frame_tick = vsync_q & ~_vsync;
  assign hit1_ev    = hit1_q & ~_hit1;
  assign hit2_ev    = hit2_q & ~_hit2;
  assign start_ev   = ~coin_q & coin_start;

  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;
  assign win_pt     = p2_pt_q ? (score2_inc == WIN4) : (score1_inc == WIN4);

  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      state_q     <= ST_ATTRACT;
      vsync_q     <= 1'b1;
      hit1_q      <= 1'b1;
      hit2_q      <= 1'b1;
      coin_q      <= 1'b0;
      timer_q     <= 8'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      dir_q       <= 1'b0;
      serve_q     <= 1'b0;
      attract_q   <= 1'b1;
      game_over_q <= 1'b0;
      speed_q     <= 2'd0;
      p2_pt_q     <= 1'b0;
`ifdef PONG_HIT_SPEEDUP_EN
      hits_q      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      vsync_q     <= _vsync;
      hit1_q      <= _hit1;
      hit2_q      <= _hit2;
      coin_q      <= coin_start;
      timer_q     <= timer_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      dir_q       <= dir_d;
      serve_q     <= serve_d;
      attract_q   <= attract_d;
      game_over_q <= game_over_d;
      speed_q     <= speed_d;
      p2_pt_q     <= p2_pt_d;
`ifdef PONG_HIT_SPEEDUP_EN
      hits_q      <= hits_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: if (start_ev) state_d = ST_SERVE_WAIT;
      ST_SERVE_WAIT: if (frame_tick && timer_q == SERVE_LAST) state_d = ST_RALLY;
      ST_RALLY:      if (miss_left || miss_right) state_d = ST_POINT;
      ST_POINT:      state_d = win_pt ? ST_GAME_OVER : ST_SERVE_WAIT;
      default:       state_d = ST_ATTRACT;
    endcase
  end

  always_comb begin
    timer_d  = timer_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    serve_d  = 1'b0;
    p2_pt_d  = p2_pt_q;
`ifdef PONG_HIT_SPEEDUP_EN
    hits_d   = hits_q;
`endif
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_ev) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          dir_d    = 1'b0;
          timer_d  = 8'd0;
`ifdef PONG_HIT_SPEEDUP_EN
          hits_d   = 3'd0;
`endif
        end
      end
      ST_SERVE_WAIT: begin
        if (frame_tick) begin
          if (timer_q == SERVE_LAST) begin
            serve_d = 1'b1;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      ST_RALLY: begin
        // A miss always beats a hit in the same cycle; left miss beats right miss.
        if (miss_left) begin
          p2_pt_d = 1'b1;
        end else if (miss_right) begin
          p2_pt_d = 1'b0;
        end else if ((hit1_ev && dir_q) || (hit2_ev && !dir_q)) begin
          dir_d = ~dir_q;
`ifdef PONG_HIT_SPEEDUP_EN
          if (hits_q != 3'd7) hits_d = hits_q + 3'd1;
`endif
        end
      end
      ST_POINT: begin
        if (p2_pt_q) begin
          if (score2_q != WIN4) score2_d = score2_inc;
          dir_d = 1'b1;
        end else begin
          if (score1_q != WIN4) score1_d = score1_inc;
          dir_d = 1'b0;
        end
        timer_d = 8'd0;
`ifdef PONG_HIT_SPEEDUP_EN
        hits_d  = 3'd0;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    attract_d   = (state_d == ST_ATTRACT) || (state_d == ST_GAME_OVER);
    game_over_d = (state_d == ST_GAME_OVER);
`ifdef PONG_HIT_SPEEDUP_EN
    case (hits_d)
      3'd0, 3'd1:       speed_d = 2'd0;
      3'd2, 3'd3:       speed_d = 2'd1;
      3'd4, 3'd5, 3'd6: speed_d = 2'd2;
      default:          speed_d = 2'd3;
    endcase
`else
    speed_d = 2'd0;
`endif
  end

  assign attract   = attract_q;
  assign serve     = serve_q;
  assign ball_dir  = dir_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign speed     = speed_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (SERVE_FRAMES=3, WIN_SCORE=6).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, vsync_n, hit1_n, hit2_n, miss_l, miss_r, coin;
  logic       attract, serve, ball_dir, game_over;
  logic [3:0] score1, score2;
  logic [1:0] speed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.SERVE_FRAMES(3), .WIN_SCORE(6)) dut (
    .clk7_159  (clk),
    ._reset    (rst_n),
    ._vsync    (vsync_n),
    ._hit1     (hit1_n),
    ._hit2     (hit2_n),
    .miss_left (miss_l),
    .miss_right(miss_r),
    .coin_start(coin),
    .attract   (attract),
    .serve     (serve),
    .ball_dir  (ball_dir),
    .score1    (score1),
    .score2    (score2),
    .speed     (speed),
    .game_over (game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_speed(input int hits);
`ifdef PONG_HIT_SPEEDUP_EN
    if (hits >= 7) return 2'd3;
    if (hits >= 4) return 2'd2;
    if (hits >= 2) return 2'd1;
    return 2'd0;
`else
    return (hits < 0) ? 2'd1 : 2'd0;
`endif
  endfunction

  // One frame: vsync low for a clock then high; returns serve as seen one clock after the fall.
  task automatic frame(output logic srv);
    vsync_n = 1'b0;
    tick();
    srv = serve;
    vsync_n = 1'b1;
    tick();
  endtask

  // Full serve sequence from SERVE_WAIT with timer cleared.
  task automatic do_serve(input string tag);
    logic s;
    frame(s);
    chk({tag, "_f1"}, {7'd0, s}, 8'd0);
    frame(s);
    chk({tag, "_f2"}, {7'd0, s}, 8'd0);
    vsync_n = 1'b0;
    tick();
    chk({tag, "_pulse"}, {7'd0, serve}, 8'd1);
    vsync_n = 1'b1;
    tick();
    chk({tag, "_pulse_end"}, {7'd0, serve}, 8'd0);
  endtask

  initial begin
    logic s, seen, exp_dir;
    int toggles;
    rst_n = 1'b0; vsync_n = 1'b1; hit1_n = 1'b1; hit2_n = 1'b1;
    miss_l = 1'b0; miss_r = 1'b0; coin = 1'b0;
    repeat (3) tick();
    chk("rst_attract", {7'd0, attract}, 8'd1);
    chk("rst_serve", {7'd0, serve}, 8'd0);
    chk("rst_dir", {7'd0, ball_dir}, 8'd0);
    chk("rst_s1", {4'd0, score1}, 8'd0);
    chk("rst_s2", {4'd0, score2}, 8'd0);
    chk("rst_speed", {6'd0, speed}, 8'd0);
    chk("rst_go", {7'd0, game_over}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Attract ignores misses and frames
    miss_r = 1'b1; tick(); tick(); miss_r = 1'b0;
    frame(s);
    chk("attr_s1", {4'd0, score1}, 8'd0);
    chk("attr_hold", {7'd0, attract}, 8'd1);

    coin = 1'b1;
    tick();
    chk("start_attract", {7'd0, attract}, 8'd0);
    coin = 1'b0;
    tick();
    do_serve("serve1");
    chk("serve1_dir", {7'd0, ball_dir}, 8'd0);

    // Rally hit acceptance
    hit1_n = 1'b0; tick();
    chk("hit1_wrong_dir", {7'd0, ball_dir}, 8'd0);
    hit1_n = 1'b1; tick();
    hit2_n = 1'b0; tick();
    chk("hit2_accept", {7'd0, ball_dir}, 8'd1);
    chk("hit2_speed", {6'd0, speed}, {6'd0, exp_speed(1)});
    toggles = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (ball_dir !== 1'b1) toggles++;
    end
    chk("hit2_held_once", toggles[7:0], 8'd0);
    hit2_n = 1'b1; tick();
    hit1_n = 1'b0; tick();
    chk("hit1_accept", {7'd0, ball_dir}, 8'd0);
    chk("hit1_speed", {6'd0, speed}, {6'd0, exp_speed(2)});
    hit1_n = 1'b1; tick();

    // miss_right -> player 1 point
    miss_r = 1'b1; tick(); miss_r = 1'b0; tick();
    chk("mr_s1", {4'd0, score1}, 8'd1);
    chk("mr_s2", {4'd0, score2}, 8'd0);
    chk("mr_dir", {7'd0, ball_dir}, 8'd0);
    chk("mr_speed", {6'd0, speed}, 8'd0);
    chk("mr_attract", {7'd0, attract}, 8'd0);
    do_serve("serve2");

    // miss_left with an otherwise-accepted hit2 edge: miss wins
    hit2_n = 1'b0; miss_l = 1'b1; tick();
    chk("ml_hit_discard", {7'd0, ball_dir}, 8'd0);
    hit2_n = 1'b1; miss_l = 1'b0; tick();
    chk("ml_s2", {4'd0, score2}, 8'd1);
    chk("ml_s1", {4'd0, score1}, 8'd1);
    chk("ml_dir", {7'd0, ball_dir}, 8'd1);

    // Both misses together: left wins
    do_serve("serve3");
    miss_l = 1'b1; miss_r = 1'b1; tick(); miss_l = 1'b0; miss_r = 1'b0; tick();
    chk("both_s2", {4'd0, score2}, 8'd2);
    chk("both_s1", {4'd0, score1}, 8'd1);

    // Build score1 up to 5
    for (int k = 2; k <= 5; k++) begin
      do_serve("serve_p1");
      miss_r = 1'b1; tick(); miss_r = 1'b0; tick();
      chk("p1_score", {4'd0, score1}, k[7:0]);
    end

    // Reset mid SERVE_WAIT with timer = 2
    frame(s);
    frame(s);
    chk("pre_rst_noserve", {7'd0, serve}, 8'd0);
    rst_n = 1'b0; tick();
    chk("mid_rst_attract", {7'd0, attract}, 8'd1);
    chk("mid_rst_s1", {4'd0, score1}, 8'd0);
    chk("mid_rst_s2", {4'd0, score2}, 8'd0);
    chk("mid_rst_serve", {7'd0, serve}, 8'd0);
    rst_n = 1'b1; tick();
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frame(s);
      seen = seen | s;
    end
    chk("post_rst_noserve", {7'd0, seen}, 8'd0);
    chk("post_rst_attract", {7'd0, attract}, 8'd1);

    // Play to game over on player 2
    coin = 1'b1; tick(); coin = 1'b0; tick();
    for (int k = 1; k <= 6; k++) begin
      do_serve("serve_p2");
      miss_l = 1'b1; tick(); miss_l = 1'b0; tick();
      chk("p2_score", {4'd0, score2}, k[7:0]);
      chk("p2_go", {7'd0, game_over}, (k == 6) ? 8'd1 : 8'd0);
    end
    chk("go_attract", {7'd0, attract}, 8'd1);
    miss_l = 1'b1; tick(); tick(); miss_l = 1'b0;
    miss_r = 1'b1; tick(); tick(); miss_r = 1'b0;
    frame(s);
    frame(s);
    frame(s);
    chk("go_hold_s2", {4'd0, score2}, 8'd6);
    chk("go_hold_s1", {4'd0, score1}, 8'd0);
    chk("go_noserve", {7'd0, serve}, 8'd0);
    coin = 1'b1; tick();
    chk("restart_s2", {4'd0, score2}, 8'd0);
    chk("restart_go", {7'd0, game_over}, 8'd0);
    chk("restart_attract", {7'd0, attract}, 8'd0);
    chk("restart_dir", {7'd0, ball_dir}, 8'd0);
    coin = 1'b0; tick();

    // Alternating accepted hits and speed progression
    do_serve("serve_spd");
    exp_dir = 1'b0;
    for (int h = 1; h <= 8; h++) begin
      if (!exp_dir) hit2_n = 1'b0; else hit1_n = 1'b0;
      tick();
      exp_dir = ~exp_dir;
      chk("spd_dir", {7'd0, ball_dir}, {7'd0, exp_dir});
      chk("spd_level", {6'd0, speed}, {6'd0, exp_speed(h)});
      hit1_n = 1'b1; hit2_n = 1'b1;
      tick();
    end
    miss_l = 1'b1; tick(); miss_l = 1'b0; tick();
    chk("spd_miss_reset", {6'd0, speed}, 8'd0);
    chk("spd_miss_s2", {4'd0, score2}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game sequencer for the Pong video/hit datapath.
- Consumes the active-low paddle-hit strobes and frame sync produced by the video generator, plus ball-miss flags from the ball position logic.
- Runs the attract / serve / rally / point / game-over flow, owns both scores, ball horizontal direction and serve timing.
- Drives the serve pulse and speed level back into the ball motion counters.

Parameters:
- SERVE_FRAMES, 60, frames between entering SERVE_WAIT and the serve pulse (legal 1..255).
- WIN_SCORE, 11, score at which the game ends (legal 1..15).

Ports:
- clk7_159  in  1  pixel clock; the only clock.
- _reset  in  1  synchronous, active-low reset.
- _vsync  in  1  active-low vertical sync; its falling edge is the frame tick.
- _hit1  in  1  active-low, ball overlapping paddle 1 (left).
- _hit2  in  1  active-low, ball overlapping paddle 2 (right).
- miss_left  in  1  ball has passed the left edge (point to player 2).
- miss_right  in  1  ball has passed the right edge (point to player 1).
- coin_start  in  1  start request, level; its rising edge is used.
- attract  out  1  high in ATTRACT and GAME_OVER.
- serve  out  1  one-clock pulse launching the ball.
- ball_dir  out  1  0 = moving right (toward paddle 2), 1 = moving left.
- score1  out  4  player 1 score.
- score2  out  4  player 2 score.
- speed  out  2  ball speed level.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Clock and reset: one clock, clk7_159. _reset is synchronous and active-low.
- Reset values: state = ATTRACT, attract = 1, serve = 0, ball_dir = 0, score1 = score2 = 0, speed = 0, game_over = 0, serve timer = 0, all edge-detect registers = inactive level.
- Reset asserted mid-operation returns to exactly these values on the next clock edge.
- Edge detection: registered copies of _vsync, _hit1, _hit2 and coin_start.
  - frame_tick = _vsync falling edge.
  - hit1_ev = _hit1 falling edge; hit2_ev = _hit2 falling edge.
  - start_ev = coin_start rising edge.
  - Each event is asserted one clock after the input edge.
- ATTRACT:
  - On start_ev: clear scores and speed, set ball_dir = 0, clear the timer, go to SERVE_WAIT.
  - All other inputs are ignored.
- SERVE_WAIT:
  - attract = 0. The timer increments on each frame_tick.
  - On the frame_tick where the timer equals SERVE_FRAMES-1: serve = 1 for that one clock, timer cleared, go to RALLY.
  - hit and miss events are ignored.
- RALLY:
  - hit1_ev is accepted only when ball_dir = 1: set ball_dir = 0.
  - hit2_ev is accepted only when ball_dir = 0: set ball_dir = 1.
  - Simultaneous hit1_ev and hit2_ev: only the one consistent with the current ball_dir is taken.
  - miss_left (level) → record point for player 2, go to POINT.
  - miss_right (level) → record point for player 1, go to POINT.
  - A miss in the same cycle as a hit: the miss wins and the hit is discarded.
  - miss_left and miss_right together: miss_left wins.
  - start_ev is ignored.
- POINT (exactly one clock):
  - Increment the recorded scorer's score, 4-bit.
  - Set ball_dir toward the conceding player: 1 after miss_left, 0 after miss_right.
  - Reset speed to 0.
  - If the new score equals WIN_SCORE, go to GAME_OVER; else go to SERVE_WAIT with the timer cleared.
- GAME_OVER:
  - attract = 1, game_over = 1. Scores are held for display.
  - start_ev behaves exactly as in ATTRACT.
- Scores never exceed WIN_SCORE and never wrap.
- Encoding: one state register, binary-encoded; all outputs registered.

Optional Feature:
- Macro: PONG_HIT_SPEEDUP_EN.
- Defined:
  - A 3-bit accepted-hit counter counts accepted hits in RALLY, saturating at 7.
  - speed = 0 for 0-1 hits, 1 for 2-3 hits, 2 for 4-6 hits, 3 for 7 hits.
  - The counter clears in POINT and on start_ev.
- Not defined: the counter is absent and speed is tied to 0.

Test Plan:
- Reset with _reset = 0 for 3 clocks, then start_ev → attract 1→0, state SERVE_WAIT; with SERVE_FRAMES = 3, serve pulses exactly one clock, one clock after the 3rd _vsync falling edge; ball_dir = 0.
- In RALLY with ball_dir = 0: pulse _hit1 low → no change. Hold _hit2 low for 20 clocks → ball_dir = 1 exactly once, 1 clock after the edge. Then _hit1 low → ball_dir = 0.
- miss_right in RALLY → score1 = 1, ball_dir = 0, back to SERVE_WAIT. miss_left in the same cycle as an accepted _hit2 edge → score2 +1, ball_dir = 1, hit ignored.
- WIN_SCORE = 2: two miss_left events → score2 = 2, game_over = 1, attract = 1. Further misses leave the scores unchanged. coin_start rising → scores 0, SERVE_WAIT.
- Assert _reset low during SERVE_WAIT with timer = 2 and score1 = 5 → next clock: ATTRACT, scores 0, serve never pulses afterwards without start_ev.
- PONG_HIT_SPEEDUP_EN defined: 7 alternating accepted hits → speed sequence 0,1,1,2,2,2,3. An 8th hit keeps speed 3. miss → speed 0. Undefined build: speed stays 0 throughout.
